calc_rr_scheduler: RTL and testbench
====================================

// Module: calc_rr_scheduler
// PURPOSE
//  Shares one iterative calculation datapath (register file, accumulator register, iteration
//  counter) between N_CLIENTS requesters. Sequences the datapath control lines: clear, operand
//  write, count/load enable.
//  Grants clients in round-robin order and returns completion to the granted client via a
//  valid/ready handshake.
//  Adds a watchdog so a datapath that never raises its carry-out cannot hang the system.
// PARAMETERS
//  N_CLIENTS   4    number of requesters, >=1
//  MAX_CYCLES  64   RUN-state cycle limit before forced completion with error, >=2
//  ID_W        $clog2(N_CLIENTS) (min 1)  width of grant id / operand select
// PORTS
//  clk         in   1          rising-edge clock, single clock domain
//  rst         in   1          asynchronous, active-low reset
//  req_valid   in   N_CLIENTS  per-client job request; held until matching req_ready
//  req_ready   out  N_CLIENTS  one-hot accept strobe, 1 cycle
//  resp_valid  out  N_CLIENTS  one-hot result available for granted client
//  resp_ready  in   N_CLIENTS  per-client result acknowledge
//  resp_error  out  1          qualifies resp_valid: 1 = watchdog expired
//  dp_sel      out  ID_W       datapath operand/result mux select (= grant_id)
//  dp_clr      out  1          clear datapath registers
//  dp_write    out  1          write selected client operands into register file
//  dp_cnt_en   out  1          iteration counter enable
//  dp_ld       out  1          accumulator load
//  dp_cout     in   1          iteration counter carry-out (calculation done)
//  busy        out  1          1 in any state except IDLE
//  grant_id    out  ID_W       currently/last granted client
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, grant_id=0, rr pointer=N_CLIENTS-1 (client 0 wins first),
//   wd_cnt=0, err_q=0.
//   Outputs during reset: dp_clr=1; all other outputs 0.
//  Reset mid-job aborts silently: no resp_valid, no pending state retained.
//  FSM (registered state; outputs decoded from state + grant_id):
//   IDLE: dp_clr=1. If |req_valid: winner = first set bit searching from ptr+1 upward, wrapping.
//     req_ready[winner]=1 same cycle (only Mealy output). grant_id<=winner, next LOAD.
//   LOAD: dp_write=1, dp_sel=grant_id; wd_cnt<=0; next RUN unconditionally.
//   RUN: dp_cnt_en=dp_ld=1; wd_cnt<=wd_cnt+1.
//     dp_cout=1 -> RESP with err_q<=0.
//     Else wd_cnt==MAX_CYCLES-1 -> RESP with err_q<=1.
//     dp_cout and watchdog in the same cycle -> err_q<=0 (normal completion wins).
//   RESP: resp_valid[grant_id]=1, resp_error=err_q. Hold until resp_ready[grant_id]=1.
//     Then ptr<=grant_id, next IDLE.
//  resp_ready from non-granted clients ignored. req_valid ignored outside IDLE (req_ready=0).
//  dp_sel=grant_id in every state; datapath outputs are valid only while resp_valid is high.
//  Min job time: 4 cycles (IDLE accept, LOAD, RUN x1, RESP x1). Back-to-back jobs get no
//   extra bubble beyond IDLE.
//  N_CLIENTS=1: arbiter degenerates to req_valid[0]; ID_W=1, grant_id stays 0.
//  All outputs are glitch-free decodes of flops except req_ready (comb. from req_valid+ptr).
//  wd_cnt width $clog2(MAX_CYCLES)+1; no wrap possible.
// STRUCTURE
//  calc_sched_pkg: state_e enum {IDLE, LOAD, RUN, RESP} (2-bit),
//   function for one-hot decode of an ID.
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs winner id and any_req; purely
//   combinational rotate-priority encoder.
//  Top holds FSM, grant/ptr/wd_cnt/err flops, output decode.
// TESTING
//  1 Reset: rst=0 async mid-cycle -> outputs all 0 except dp_clr=1, busy=0 immediately.
//    Release, req_valid=4'b0001 -> req_ready=0001 same cycle, then LOAD, RUN.
//  2 Single job: dp_cout=1 after 3 RUN cycles -> resp_valid=0001, resp_error=0.
//    resp_ready held 0 for 5 cycles -> resp_valid stays; ready=1 -> IDLE next cycle.
//  3 Round-robin: req_valid=4'b1111 held -> grants 0,1,2,3,0 in order.
//    Then req_valid=4'b1001 after grant 3 -> next grant 0, then 3.
//  4 Watchdog: dp_cout never set -> RESP after exactly MAX_CYCLES RUN cycles with
//    resp_error=1.
//    dp_cout on cycle MAX_CYCLES-1 -> resp_error=0.
//  5 Handshake isolation: in RESP for client 2, resp_ready=4'b0001 -> no exit.
//    req_valid from other clients during RUN -> req_ready stays 0000.
//  6 Reset mid-RUN: rst=0 at RUN cycle 2 -> IDLE; no resp_valid.
//    Next request from client 0 is granted first (pointer reset).

Source files
------------

// File: rtl/calc_rr_scheduler_pkg.sv
// rtl/calc_rr_scheduler_pkg.sv - shared types and helpers for the round-robin calc scheduler
// Purpose: FSM state encoding and an ID-to-one-hot bit helper used by the top and bench.
// Ports: none (package).
package calc_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  // One bit of the one-hot decode of id: 1 when bit position pos belongs to id.
  function automatic logic onehot_bit(input int unsigned id, input int unsigned pos);
    return id == pos;
  endfunction

endpackage

// File: rtl/calc_rr_scheduler_if.sv
// rtl/calc_rr_scheduler_if.sv - client handshake and datapath control bundle
// Purpose: groups request/response handshakes, datapath control lines and status.
// Ports (signals):
//   req_valid/req_ready   per-client job request and one-cycle accept strobe
//   resp_valid/resp_ready per-client completion handshake, resp_error qualifies it
//   dp_sel/dp_clr/dp_write/dp_cnt_en/dp_ld  datapath control, dp_cout datapath done
//   busy/grant_id         scheduler status
// Modports: slave = scheduler side, master = clients/datapath side.
interface calc_rr_scheduler_if #(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = 2
);
  logic [N_CLIENTS-1:0] req_valid;
  logic [N_CLIENTS-1:0] req_ready;
  logic [N_CLIENTS-1:0] resp_valid;
  logic [N_CLIENTS-1:0] resp_ready;
  logic                 resp_error;
  logic [ID_W-1:0]      dp_sel;
  logic                 dp_clr;
  logic                 dp_write;
  logic                 dp_cnt_en;
  logic                 dp_ld;
  logic                 dp_cout;
  logic                 busy;
  logic [ID_W-1:0]      grant_id;

  modport slave (
    input  req_valid, resp_ready, dp_cout,
    output req_ready, resp_valid, resp_error, dp_sel, dp_clr, dp_write,
           dp_cnt_en, dp_ld, busy, grant_id
  );

  modport master (
    output req_valid, resp_ready, dp_cout,
    input  req_ready, resp_valid, resp_error, dp_sel, dp_clr, dp_write,
           dp_cnt_en, dp_ld, busy, grant_id
  );

endinterface

// File: rtl/calc_rr_scheduler_rr_arbiter.sv
// rtl/calc_rr_scheduler_rr_arbiter.sv - combinational rotate-priority encoder
// Purpose: picks the first requesting client searching upward from ptr+1, wrapping.
// Ports:
//   req      in   N      request vector
//   ptr      in   ID_W   last served client
//   winner   out  ID_W   selected client (0 when no request)
//   any_req  out  1      at least one request present
module calc_rr_scheduler_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            any_req
);

  int   idx;
  logic found;

  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    // Offsets 1..N visit every client once, ending on ptr itself so a lone
    // requester that was just served still wins.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/calc_rr_scheduler.sv
// rtl/calc_rr_scheduler.sv - round-robin scheduler sharing one iterative calc datapath
// Purpose: grants clients in round-robin order, sequences clear/write/run of the shared
//   datapath, returns completion via valid/ready, and forces completion with an error
//   flag when the datapath never raises dp_cout within MAX_CYCLES RUN cycles.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset
//   bus  slave modport of calc_rr_scheduler_if (handshakes, datapath control, status)
module calc_rr_scheduler
  import calc_rr_scheduler_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int MAX_CYCLES = 64,
  parameter int ID_W       = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input logic               clk,
  input logic               rst,
  calc_rr_scheduler_if.slave bus
);

  localparam int              WD_W    = $clog2(MAX_CYCLES) + 1;
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_CLIENTS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  err_q, err_d;
  logic                  dp_clr_q, dp_clr_d;
  logic                  dp_write_q, dp_write_d;
  logic                  dp_run_q, dp_run_d;
  logic                  busy_q, busy_d;
  logic                  resp_error_q, resp_error_d;
  logic [N_CLIENTS-1:0]  resp_valid_q, resp_valid_d;
  logic [N_CLIENTS-1:0]  req_ready;
  logic [ID_W-1:0]       winner;
  logic                  any_req;

  calc_rr_scheduler_rr_arbiter #(
    .N    (N_CLIENTS),
    .ID_W (ID_W)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // The only Mealy output; gated by rst so nothing is accepted while in reset.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      req_ready[i] = rst && (state_q == IDLE) && any_req && onehot_bit(32'(winner), i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = wd_q + 1'b1;
        // Normal completion takes priority over a simultaneous watchdog expiry.
        if (bus.dp_cout) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready[grant_q]) begin
          ptr_d   = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered: decoded from the next state so they line up with state_q.
    dp_clr_d     = (state_d == IDLE);
    dp_write_d   = (state_d == LOAD);
    dp_run_d     = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    resp_error_d = (state_d == RESP) && err_d;
    resp_valid_d = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      resp_valid_d[i] = (state_d == RESP) && onehot_bit(32'(grant_d), i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= PTR_RST;
      wd_q         <= '0;
      err_q        <= 1'b0;
      dp_clr_q     <= 1'b1;
      dp_write_q   <= 1'b0;
      dp_run_q     <= 1'b0;
      busy_q       <= 1'b0;
      resp_error_q <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      dp_clr_q     <= dp_clr_d;
      dp_write_q   <= dp_write_d;
      dp_run_q     <= dp_run_d;
      busy_q       <= busy_d;
      resp_error_q <= resp_error_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.dp_sel     = grant_q;
  assign bus.dp_clr     = dp_clr_q;
  assign bus.dp_write   = dp_write_q;
  assign bus.dp_cnt_en  = dp_run_q;
  assign bus.dp_ld      = dp_run_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// tb/tb_calc_rr_scheduler.sv - scoreboard bench for calc_rr_scheduler
module tb_calc_rr_scheduler;

  localparam int N   = 4;
  localparam int MAX = 8;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  int   gq[$];
  int   rq_id[$];
  int   rq_err[$];

  calc_rr_scheduler_if #(.N_CLIENTS(N), .ID_W(2)) bus ();

  calc_rr_scheduler #(
    .N_CLIENTS  (N),
    .MAX_CYCLES (MAX),
    .ID_W       (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return one << g;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops expected grants and responses when the DUT presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.req_ready != 0) begin
        if (gq.size() == 0) chk("unexpected_grant", int'(bus.req_ready), 0);
        else chk("grant", int'(bus.req_ready), int'(oh(gq.pop_front())));
      end
      if (bus.resp_valid != 0 && rq_id.size() == 0)
        chk("unexpected_resp", int'(bus.resp_valid), 0);
      if ((bus.resp_valid & bus.resp_ready) != 0 && rq_id.size() != 0) begin
        chk("resp_client", int'(bus.resp_valid), int'(oh(rq_id.pop_front())));
        chk("resp_error", int'(bus.resp_error), rq_err.pop_front());
      end
    end
  end

  // run: RUN cycle on which dp_cout is raised (0 = never). hold: RESP cycles with
  // resp_ready withheld. iso: drive foreign requests in RUN and a foreign ready in RESP.
  task automatic do_job(input logic [3:0] reqs, input int g, input int run,
                        input int hold, input bit iso);
    int k;
    bit got;
    int exp_err;
    int exp_k;
    exp_err = (run == 0 || run > MAX) ? 1 : 0;
    exp_k   = (run == 0 || run > MAX) ? MAX : run;
    bus.req_valid = reqs;
    gq.push_back(g);
    rq_id.push_back(g);
    rq_err.push_back(exp_err);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    @(posedge clk); #1;
    chk("load_write", int'(bus.dp_write), 1);
    chk("load_sel", int'(bus.dp_sel), g);
    chk("load_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    if (iso) bus.req_valid = 4'b1111 & ~oh(g);
    k = 0;
    for (int c = 1; c <= MAX + 4; c++) begin
      if (!bus.dp_cnt_en) break;
      k = c;
      if (iso) chk("iso_req_ready", int'(bus.req_ready), 0);
      bus.dp_cout = (c == run);
      @(posedge clk); #1;
      bus.dp_cout = 1'b0;
    end
    chk("run_cycles", k, exp_k);
    if (iso) bus.req_valid = 4'b0000;
    bus.resp_ready = iso ? 4'b0001 : 4'b0000;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end
    chk("resp_hold_valid", int'(bus.resp_valid), int'(oh(g)));
    chk("resp_hold_error", int'(bus.resp_error), exp_err);
    bus.resp_ready = oh(g);
    @(posedge clk); #1;
    bus.resp_ready = 4'b0000;
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_clr", int'(bus.dp_clr), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.dp_cout    = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_dp_clr", int'(bus.dp_clr), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_dp_write", int'(bus.dp_write), 0);
    chk("rst_dp_cnt_en", int'(bus.dp_cnt_en), 0);
    chk("rst_dp_ld", int'(bus.dp_ld), 0);
    chk("rst_grant_id", int'(bus.grant_id), 0);
    chk("rst_resp_error", int'(bus.resp_error), 0);
    @(posedge clk); #3;
    rst = 1'b1;

    // Single job, response withheld for 5 cycles; pointer ends at 0.
    do_job(4'b0001, 0, 3, 5, 1'b0);

    // Round-robin with all clients requesting, then a sparse mask.
    do_job(4'b1111, 1, 1, 0, 1'b0);
    do_job(4'b1111, 2, 2, 1, 1'b0);
    do_job(4'b1111, 3, 5, 0, 1'b0);
    do_job(4'b1001, 0, 1, 0, 1'b0);
    do_job(4'b1001, 3, 2, 0, 1'b0);
    do_job(4'b1111, 0, 1, 0, 1'b0);

    // Watchdog: never done, done on the last allowed cycle, done on the expiry cycle.
    do_job(4'b0010, 1, 0, 0, 1'b0);
    do_job(4'b0010, 1, MAX - 1, 0, 1'b0);
    do_job(4'b0010, 1, MAX, 0, 1'b0);

    // Handshake isolation for client 2.
    do_job(4'b0100, 2, 3, 3, 1'b1);

    // Pointer to 0, then reset in the middle of a client-1 job.
    do_job(4'b0001, 0, 1, 0, 1'b0);
    bus.req_valid = 4'b0010;
    gq.push_back(1);
    @(negedge clk);
    chk("abort_grant_seen", int'(bus.req_ready), int'(oh(1)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("abort_in_run", int'(bus.dp_cnt_en), 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_resp_valid", int'(bus.resp_valid), 0);
    chk("abort_dp_clr", int'(bus.dp_clr), 1);
    chk("abort_dp_cnt_en", int'(bus.dp_cnt_en), 0);
    chk("abort_grant_id", int'(bus.grant_id), 0);
    chk("abort_req_ready", int'(bus.req_ready), 0);
    bus.req_valid = 4'b0011;
    @(posedge clk); #1;
    rst = 1'b1;
    do_job(4'b0011, 0, 2, 0, 1'b0);
    bus.req_valid = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    chk("left_grants", gq.size(), 0);
    chk("left_resps", rq_id.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
